// File: rtl/obb_pkg.sv
// Shared types for the OBB front end: sequencer state encoding, default coordinate width,
// and the packed {x,y,z} point layout used everywhere a point travels as one word.
package obb_pkg;

  localparam int OBB_CW = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_STREAM = 3'd3,
    ST_CALC   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // x occupies the MSBs, matching the {x,y,z} concatenation used on the buffer port.
  typedef struct packed {
    logic signed [OBB_CW-1:0] x;
    logic signed [OBB_CW-1:0] y;
    logic signed [OBB_CW-1:0] z;
  } point_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/obb_point_buf.sv
// One-frame point store: 1W/1R register array with independent write and read pointers.
// Read data is combinational from the read pointer; wr_clr redirects a same-cycle write to entry 0.
module obb_point_buf #(
  parameter int NPTS = 16,
  parameter int W    = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_clr,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat
);

  localparam int PW = (NPTS > 1) ? $clog2(NPTS) : 1;

  logic [W-1:0]  mem [NPTS];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NPTS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_addr = wr_clr ? '0 : wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)       wr_ptr <= ptr_inc(wr_addr);
      else if (wr_clr) wr_ptr <= '0;

      if (rd_clr)      rd_ptr <= '0;
      else if (rd_en)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage is never read before it is written within a frame, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/obb_frame_sequencer.sv
// Buffers one frame of points, clears the OBB datapath, replays the frame bubble-free and flags results.
// in_ready is high only in IDLE/FILL; first dp_valid lands CLR_CYC+1 cycles after the in_last accept.
module obb_frame_sequencer
  import obb_pkg::*;
#(
  parameter int CW       = OBB_CW,
  parameter int NPTS     = 16,
  parameter int CLR_CYC  = 5,
  parameter int CALC_LAT = 250
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CW-1:0]             in_x,
  input  logic [CW-1:0]             in_y,
  input  logic [CW-1:0]             in_z,
  input  logic                      in_last,
  output logic                      dp_clr,
  output logic                      dp_valid,
  output logic [CW-1:0]             dp_x,
  output logic [CW-1:0]             dp_y,
  output logic [CW-1:0]             dp_z,
  output logic                      res_valid,
  output logic [$clog2(NPTS+1)-1:0] frame_len,
  output logic                      busy,
  output logic                      err_trunc
);

  localparam int LEN_W   = $clog2(NPTS + 1);
  localparam int CNT_MAX = max3(CLR_CYC, NPTS, CALC_LAT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  state_t           state_nxt;
  logic             run;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic             fill_full;
  logic             clr_done;
  logic             strm_done;
  logic             calc_done;
  logic [3*CW-1:0]  rd_dat;

  assign accept    = in_valid & in_ready;
  assign fill_full = (frame_len == LEN_W'(NPTS - 1));
  assign clr_done  = (cnt == CNT_W'(CLR_CYC - 1));
  assign strm_done = (cnt == CNT_W'(frame_len) - CNT_W'(1));
  // The last STREAM cycle is the first cycle of compute latency, so CALC itself lasts CALC_LAT-1.
  assign calc_done = (cnt == CNT_W'(CALC_LAT - 2));

  // run stays low for the first cycle after reset release so dp_clr covers the whole reset window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = in_last ? ST_CLEAR : ST_FILL;
      ST_FILL:   if (accept && (in_last || fill_full)) state_nxt = ST_CLEAR;
      ST_CLEAR:  if (clr_done) state_nxt = ST_STREAM;
      ST_STREAM: if (strm_done) state_nxt = ST_CALC;
      ST_CALC:   if (calc_done) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    dp_clr    = ~run;
    dp_valid  = 1'b0;
    res_valid = 1'b0;
    busy      = (state != ST_IDLE);
    if (run) begin
      case (state)
        ST_IDLE,
        ST_FILL:   in_ready  = 1'b1;
        ST_CLEAR:  dp_clr    = 1'b1;
        ST_STREAM: dp_valid  = 1'b1;
        ST_DONE:   res_valid = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      frame_len <= '0;
      err_trunc <= 1'b0;
    end else begin
      if (state_nxt != state) cnt <= '0;
      else                    cnt <= cnt + CNT_W'(1);

      if (accept) begin
        if (state == ST_IDLE) begin
          frame_len <= LEN_W'(1);
          err_trunc <= 1'b0;
        end else begin
          frame_len <= frame_len + LEN_W'(1);
          err_trunc <= fill_full & ~in_last;
        end
      end
    end
  end

  obb_point_buf #(
    .NPTS (NPTS),
    .W    (3 * CW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_clr (state == ST_IDLE),
    .wr_en  (accept),
    .wr_dat ({in_x, in_y, in_z}),
    .rd_clr (state == ST_CLEAR),
    .rd_en  (dp_valid),
    .rd_dat (rd_dat)
  );

  assign dp_x = dp_valid ? rd_dat[3*CW-1:2*CW] : '0;
  assign dp_y = dp_valid ? rd_dat[2*CW-1:CW]   : '0;
  assign dp_z = dp_valid ? rd_dat[CW-1:0]      : '0;

endmodule

// File: tb/tb_obb_frame_sequencer.sv
// Directed bench for obb_frame_sequencer: reset, full, truncated, single-point,
// backpressured and reset-interrupted frames, checked with immediate assertions.
module tb_obb_frame_sequencer;
  import obb_pkg::*;

  localparam int CW = 10;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last  = 1'b0;
  logic [CW-1:0] in_x     = '0;
  logic [CW-1:0] in_y     = '0;
  logic [CW-1:0] in_z     = '0;
  logic          in_ready;
  logic          dp_clr;
  logic          dp_valid;
  logic [CW-1:0] dp_x;
  logic [CW-1:0] dp_y;
  logic [CW-1:0] dp_z;
  logic          res_valid;
  logic [4:0]    frame_len;
  logic          busy;
  logic          err_trunc;

  int     checks   = 0;
  int     failures = 0;
  point_t pts [0:23];

  always #5 clk = ~clk;

  obb_frame_sequencer #(
    .CW       (CW),
    .NPTS     (16),
    .CLR_CYC  (5),
    .CALC_LAT (250)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .in_last   (in_last),
    .dp_clr    (dp_clr),
    .dp_valid  (dp_valid),
    .dp_x      (dp_x),
    .dp_y      (dp_y),
    .dp_z      (dp_z),
    .res_valid (res_valid),
    .frame_len (frame_len),
    .busy      (busy),
    .err_trunc (err_trunc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives pts[base..base+n-1] one per cycle; returns at the negedge after the final accept.
  task automatic send_frame(input int base, input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_x     = pts[base+i].x;
      in_y     = pts[base+i].y;
      in_z     = pts[base+i].z;
      in_last  = last && (i == n - 1);
      chk($sformatf("fill_rdy_%0d", i), 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Starts at the negedge right after the frame's final accept; ends in IDLE after res_valid.
  task automatic expect_frame(input string tag, input int base, input int n);
    int clr_n;
    int lat;
    int rdy_seen;
    clr_n = 0;
    while (dp_clr && clr_n < 20) begin
      clr_n++;
      @(negedge clk);
    end
    chk({tag, "_clr_cycles"}, 32'(clr_n), 32'd5);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_pt%0d", tag, i), 32'({dp_valid, dp_x, dp_y, dp_z}),
          32'({1'b1, pts[base+i]}));
      @(negedge clk);
    end
    chk({tag, "_stream_end"}, 32'({dp_valid, dp_x, dp_y, dp_z}), 32'd0);
    lat      = 1;
    rdy_seen = 0;
    while (!res_valid && lat < 400) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_res_latency"}, 32'(lat), 32'd250);
    chk({tag, "_no_accept_busy"}, 32'(rdy_seen), 32'd0);
    chk({tag, "_frame_len"}, 32'(frame_len), 32'(n));
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'({res_valid, busy, in_ready}), 32'b001);
  endtask

  initial begin
    int seen;
    int guard;
    int res_cnt;

    for (int i = 0; i < 20; i++) begin
      pts[i].x = CW'(216 - 29 * i);
      pts[i].y = CW'(80 + 13 * i);
      pts[i].z = CW'(-98 + 23 * i);
    end
    // (-365, -77, -28) in 10-bit two's complement
    pts[20] = '{x: 10'h293, y: 10'h3B3, z: 10'h3E4};
    pts[21] = '{x: 10'h025, y: 10'h338, z: 10'h1FF};
    for (int i = 22; i < 24; i++) pts[i] = '0;

    // Reset held for 5 cycles
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_outputs", 32'({in_ready, dp_clr, dp_valid, res_valid, busy}), 32'b01000);
    chk("rst_len_err", 32'({frame_len, err_trunc}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst", 32'({in_ready, dp_clr, busy}), 32'b100);

    // Full 16-point frame
    send_frame(0, 16, 1'b1);
    chk("full_err_trunc", 32'(err_trunc), 32'd0);
    expect_frame("full", 0, 16);

    // Truncation: 16 accepted, the 17th is held off
    send_frame(2, 16, 1'b0);
    chk("trunc_rdy_17th", 32'(in_ready), 32'd0);
    chk("trunc_err", 32'(err_trunc), 32'd1);
    chk("trunc_len", 32'(frame_len), 32'd16);
    in_valid = 1'b1;
    in_x     = pts[18].x;
    in_y     = pts[18].y;
    in_z     = pts[18].z;
    expect_frame("trunc", 2, 16);
    in_valid = 1'b0;
    chk("trunc_err_sticky", 32'(err_trunc), 32'd1);

    // Single-point frame
    send_frame(20, 1, 1'b1);
    chk("single_len", 32'(frame_len), 32'd1);
    chk("single_err_clr", 32'(err_trunc), 32'd0);
    expect_frame("single", 20, 1);

    // Backpressure: next point held through CLEAR/STREAM/CALC/DONE
    send_frame(10, 2, 1'b1);
    in_valid = 1'b1;
    in_x     = pts[21].x;
    in_y     = pts[21].y;
    in_z     = pts[21].z;
    in_last  = 1'b1;
    expect_frame("bp", 10, 2);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_held_len", 32'(frame_len), 32'd1);
    expect_frame("bp_held", 21, 1);

    // Reset on the third dp_valid of a 4-point frame
    send_frame(4, 4, 1'b1);
    seen  = 0;
    guard = 0;
    while (guard < 50) begin
      if (dp_valid) seen++;
      if (seen == 3) break;
      @(negedge clk);
      guard++;
    end
    chk("mr_third_valid", 32'(seen), 32'd3);
    rst = 1'b0;
    #1;
    chk("mr_outputs", 32'({in_ready, dp_clr, dp_valid, res_valid, busy}), 32'b01000);
    chk("mr_len", 32'(frame_len), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    res_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (res_valid) res_cnt++;
    end
    chk("mr_no_res", 32'(res_cnt), 32'd0);
    send_frame(8, 3, 1'b1);
    expect_frame("after_rst", 8, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
